// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus: a request/address pair from the fetch unit,
// answered by valid-qualified read data from memory.
interface instr_fetch_if #(
  parameter int PC_WIDTH = 64
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_valid;
  logic [31:0]         imem_rdata;

  // imem_req/imem_addr stay constant from request until the cycle imem_valid
  // is sampled high; imem_valid means nothing while imem_req is low.
  modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one 32-bit instruction per FETCH/HOLD pair,
// holds it for the decode blocks and redirects on a taken branch.
module instr_fetch_unit #(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_if.master       imem,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [6:0]          Opcode,
  output logic [3:0]          Funct,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic                fetch_err,
  output logic [31:0]         instr_count,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  logic   req;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_out;
  assign state_dbg      = state;

  assign Opcode = instr[6:0];
  assign Funct  = {instr[30], instr[14:12]};
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_out      <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      req         <= 1'b0;
      fetch_err   <= 1'b0;
      instr_count <= '0;
    end else begin
      // fetch_err can only be raised by the HOLD->FETCH edge, so it lasts one cycle.
      fetch_err <= 1'b0;
      case (state)
        IDLE: begin
          state <= FETCH;
          req   <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_valid) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            req         <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            state       <= FETCH;
            req         <= 1'b1;
            instr_valid <= 1'b0;
            instr_count <= instr_count + 32'd1;
            if (branch_taken) begin
              pc_out    <= {branch_target[PC_WIDTH-1:2], 2'b00};
              fetch_err <= |branch_target[1:0];
            end else begin
              pc_out <= pc_out + PC_WIDTH'(4);
            end
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
